// File: rtl/forward_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : forward_stall_ctrl
// Purpose  : Forwarding-select and load-use stall control for the 5-stage
//            core. The optional stall counter is built when STALL_CNT_EN is
//            defined.
// Revision : 1.0  initial release
// ============================================================================
module forward_stall_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    // WB and the MEM-stage load flag are never consulted: the register file
    // writes through in WB, and a MEM-stage producer forwards whether or not
    // it is a load. Only the fields that steer a decision are held.
    logic              ex_wr_en;
    logic [REG_AW-1:0] ex_wr_reg;
    logic              ex_mem_read;
    logic              mem_wr_en;
    logic [REG_AW-1:0] mem_wr_reg;

    logic              ex_prod;
    logic              ex_load;
    logic              mem_prod;
    logic              kill;
    logic [1:0]        fwd_a_nxt;
    logic [1:0]        fwd_b_nxt;

    function automatic logic [1:0] pick_sel(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input logic              ex_alu,
        input logic [REG_AW-1:0] ex_reg,
        input logic              mem_p,
        input logic [REG_AW-1:0] mem_reg
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_src && ex_alu && (ex_reg == src)) begin
            sel = SEL_EXM;
        end else if (use_src && mem_p && (mem_reg == src)) begin
            sel = SEL_MWB;
        end
        return sel;
    endfunction

    always_comb begin
        ex_prod  = ex_wr_en && (ex_wr_reg != '0);
        ex_load  = ex_prod && ex_mem_read;
        mem_prod = mem_wr_en && (mem_wr_reg != '0);

        stall = id_valid && !flush && ex_load &&
                ((id_use_rs && (id_rs == ex_wr_reg)) ||
                 (id_use_rt && (id_rt == ex_wr_reg)));
        kill  = flush || stall || !id_valid;

        fwd_a_nxt = SEL_RF;
        fwd_b_nxt = SEL_RF;
        if (!kill) begin
            fwd_a_nxt = pick_sel(id_use_rs, id_rs, ex_prod && !ex_mem_read,
                                 ex_wr_reg, mem_prod, mem_wr_reg);
            fwd_b_nxt = pick_sel(id_use_rt, id_rt, ex_prod && !ex_mem_read,
                                 ex_wr_reg, mem_prod, mem_wr_reg);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_wr_en    <= 1'b0;
            ex_wr_reg   <= '0;
            ex_mem_read <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_reg  <= '0;
            ex_bubble   <= 1'b0;
            fwd_a       <= SEL_RF;
            fwd_b       <= SEL_RF;
        end else begin
            mem_wr_en   <= ex_wr_en;
            mem_wr_reg  <= ex_wr_reg;
            ex_wr_en    <= !kill && id_wr_en;
            ex_wr_reg   <= kill ? '0 : id_wr_reg;
            ex_mem_read <= !kill && id_mem_read;
            ex_bubble   <= stall || flush;
            fwd_a       <= fwd_a_nxt;
            fwd_b       <= fwd_b_nxt;
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_forward_stall_ctrl
// Purpose  : Directed hazard scenarios plus random traffic against an
//            instruction-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_forward_stall_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_use_rs, id_use_rt, id_wr_en, id_mem_read, flush;
    logic [REG_AW-1:0] id_rs, id_rt, id_wr_reg;
    logic              stall, ex_bubble;
    logic [1:0]        fwd_a, fwd_b;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    forward_stall_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_mem_read(id_mem_read),
        .flush      (flush),
        .stall      (stall),
        .ex_bubble  (ex_bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: the last two instructions issued into EX, newest first.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } ent_t;

    ent_t        hist [2];
    logic        exp_bubble;
    logic [1:0]  exp_fa, exp_fb;
    int unsigned exp_cnt;
    logic        dut_stall;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist[0] = '0;
        hist[1] = '0;
        exp_bubble = 1'b0;
        exp_fa = 2'b00;
        exp_fb = 2'b00;
        exp_cnt = 0;
    endtask

    function automatic logic model_stall();
        if (!id_valid || flush || !hist[0].we || !hist[0].ld || hist[0].rd == 0)
            return 1'b0;
        return (id_use_rs && id_rs == hist[0].rd) || (id_use_rt && id_rt == hist[0].rd);
    endfunction

    // Youngest matching producer wins; one back forwards from EX/MEM, two back from MEM/WB.
    function automatic logic [1:0] exp_sel(input logic use_src, input logic [REG_AW-1:0] r);
        if (!use_src || r == 0) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (hist[d].we && hist[d].rd == r)
                return (d == 0) ? (hist[d].ld ? 2'b00 : 2'b01) : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic step(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [REG_AW-1:0] wr, input logic ld, input logic fl);
        logic       es, kill;
        logic [1:0] na, nb;
        ent_t       iss;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = we; id_wr_reg = wr; id_mem_read = ld; flush = fl;
        #1;
        es = model_stall();
        dut_stall = stall;
        check("stall", {31'd0, stall}, {31'd0, es});
        kill = fl || es || !v;
        na = kill ? 2'b00 : exp_sel(urs, rs);
        nb = kill ? 2'b00 : exp_sel(urt, rt);
        iss = kill ? '0 : {we, wr, ld};
        @(posedge clk);
        hist[1] = hist[0];
        hist[0] = iss;
        exp_fa = na;
        exp_fb = nb;
        exp_bubble = es || fl;
        if (es && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
        #1;
        check("fwd_a", {30'd0, fwd_a}, {30'd0, exp_fa});
        check("fwd_b", {30'd0, fwd_b}, {30'd0, exp_fb});
        check("ex_bubble", {31'd0, ex_bubble}, {31'd0, exp_bubble});
`ifdef STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), exp_cnt);
`endif
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int unsigned cnt_before;
        reset = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; id_mem_read = 0; flush = 0;
        model_reset();
        #12;
        check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        check("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
        check("rst_bubble", {31'd0, ex_bubble}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU -> ALU at distance one
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
        step(1, 5'd3, 5'd4, 1, 1, 1, 5'd6, 0, 0);
        check("t1_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("t1_nostall", {31'd0, dut_stall}, 32'd0);

        // distance two on operand B
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 0);
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0, 0);
        step(1, 5'd9, 5'd5, 1, 1, 1, 5'd10, 0, 0);
        check("t2_fwd_b", {30'd0, fwd_b}, 32'd2);

        // newer producer wins
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 0);
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 0);
        step(1, 5'd5, 5'd2, 1, 1, 1, 5'd11, 0, 0);
        check("t3_fwd_a", {30'd0, fwd_a}, 32'd1);

        // load-use: one stall, then MEM/WB forward
        idle();
        step(1, 5'd1, 5'd2, 1, 0, 1, 5'd8, 1, 0);
        cnt_before = exp_cnt;
        step(1, 5'd8, 5'd2, 1, 1, 1, 5'd12, 0, 0);
        check("t4_stall", {31'd0, dut_stall}, 32'd1);
        check("t4_bubble", {31'd0, ex_bubble}, 32'd1);
        check("t4_fwd_held", {30'd0, fwd_a}, 32'd0);
        step(1, 5'd8, 5'd2, 1, 1, 1, 5'd12, 0, 0);
        check("t4_stall_gone", {31'd0, dut_stall}, 32'd0);
        check("t4_fwd_a", {30'd0, fwd_a}, 32'd2);
`ifdef STALL_CNT_EN
        check("t4_cnt", 32'(stall_cnt), cnt_before + 1);
`endif

        // register 0 never forwards or stalls
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0);
        step(1, 5'd0, 5'd0, 1, 1, 1, 5'd13, 0, 0);
        check("t5_fwd_a", {30'd0, fwd_a}, 32'd0);
        check("t5_fwd_b", {30'd0, fwd_b}, 32'd0);
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 1, 0);
        step(1, 5'd0, 5'd0, 1, 1, 1, 5'd14, 0, 0);
        check("t5_ld0_stall", {31'd0, dut_stall}, 32'd0);

        // flush beats load-use stall
        idle();
        step(1, 5'd1, 5'd2, 1, 0, 1, 5'd8, 1, 0);
        step(1, 5'd8, 5'd2, 1, 1, 1, 5'd12, 0, 1);
        check("t6_stall", {31'd0, dut_stall}, 32'd0);
        check("t6_bubble", {31'd0, ex_bubble}, 32'd1);
        check("t6_fwd_a", {30'd0, fwd_a}, 32'd0);

        // asynchronous reset while stalling
        step(1, 5'd1, 5'd2, 1, 0, 1, 5'd9, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 5'd9; id_use_rs = 1; id_use_rt = 0;
        id_wr_en = 1; id_wr_reg = 5'd15; id_mem_read = 0; flush = 0;
        #1;
        check("t6_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_stall", {31'd0, stall}, 32'd0);
        check("t6_rst_bubble", {31'd0, ex_bubble}, 32'd0);
        check("t6_rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
`ifdef STALL_CNT_EN
        check("t6_rst_cnt", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        id_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        idle();

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(9) != 0,
                 REG_AW'($urandom_range(3)), REG_AW'($urandom_range(3)),
                 1'($urandom), 1'($urandom), $urandom_range(3) != 0,
                 REG_AW'($urandom_range(3)), $urandom_range(2) == 0,
                 $urandom_range(9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
